// File: rtl/arb_bus_mux_if.sv
// Bus bundle between the four burst masters, the arbiter grant and the shared slave port.
// Latency: none (wires only).
// Backpressure: carried by s_ready and mirrored back to the owning master as m_ready.
// Ports: grant/m_* come from the masters and arbiter; s_* form the shared slave port;
//        owner/bus_busy/grant_err are status. Modport slave is the mux side, master the driver side.
interface arb_bus_mux_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
) ();
  logic [3:0]          grant;
  logic [3:0]          m_valid;
  logic [4*ADDR_W-1:0] m_addr;
  logic [4*DATA_W-1:0] m_wdata;
  logic [4*LEN_W-1:0]  m_len;
  logic [3:0]          m_ready;
  logic [3:0]          m_done;
  logic                s_valid;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_wdata;
  logic                s_last;
  logic                s_ready;
  logic [1:0]          owner;
  logic                bus_busy;
  logic                grant_err;

  modport slave (
    input  grant, m_valid, m_addr, m_wdata, m_len, s_ready,
    output m_ready, m_done, s_valid, s_addr, s_wdata, s_last, owner, bus_busy, grant_err
  );

  modport master (
    output grant, m_valid, m_addr, m_wdata, m_len, s_ready,
    input  m_ready, m_done, s_valid, s_addr, s_wdata, s_last, owner, bus_busy, grant_err
  );
endinterface

// File: rtl/arb_bus_mux.sv
// Locks the shared slave bus to the granted master for a whole burst and muxes its beats out.
// Latency: grant sampled at edge N gives the first s_valid in cycle N+1; one RELEASE cycle after the last beat.
// Backpressure: s_ready stalls the beat counter and is mirrored to the owner's m_ready; owner m_valid low stalls too.
// Ports: clk, rst_an (async active-low), bus (arb_bus_mux_if.slave).
module arb_bus_mux #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
) (
  input  logic         clk,
  input  logic         rst_an,
  arb_bus_mux_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BURST   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic [LEN_W-1:0]  rem_q,   rem_d;
  logic [LEN_W-1:0]  beat_q,  beat_d;
  logic              gerr_q,  gerr_d;

  // Grant decode: index of the (last) set bit plus a population count.
  logic [1:0]        gnt_idx;
  logic [2:0]        gnt_cnt;
  logic              gnt_valid;
  logic [ADDR_W-1:0] gnt_addr;
  logic [LEN_W-1:0]  gnt_len;

  always_comb begin
    gnt_idx = 2'd0;
    gnt_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.grant[i]) begin
        gnt_idx = 2'(i);
        gnt_cnt = gnt_cnt + 3'd1;
      end
    end
  end

  // Constant-index muxes keep the part-selects static.
  logic              own_valid;
  logic [DATA_W-1:0] own_wdata;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_addr  = '0;
    gnt_len   = '0;
    own_valid = 1'b0;
    own_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_idx == 2'(i)) begin
        gnt_valid = bus.m_valid[i];
        gnt_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
        gnt_len   = bus.m_len[i*LEN_W +: LEN_W];
      end
      if (owner_q == 2'(i)) begin
        own_valid = bus.m_valid[i];
        own_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  logic in_burst, in_rel, s_valid_w, xfer;
  assign in_burst  = (state_q == ST_BURST);
  assign in_rel    = (state_q == ST_RELEASE);
  assign s_valid_w = in_burst & own_valid;
  assign xfer      = s_valid_w & bus.s_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    gerr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_cnt == 3'd1 && gnt_valid) begin
          state_d = ST_BURST;
          owner_d = gnt_idx;
          base_d  = gnt_addr;
          rem_d   = gnt_len;
          beat_d  = '0;
        end else if (gnt_cnt > 3'd1) begin
          gerr_d = 1'b1;
        end
      end
      ST_BURST: begin
        // Grant is deliberately ignored here: ownership holds until RELEASE.
        if (xfer) begin
          if (rem_q == '0) begin
            state_d = ST_RELEASE;
          end else begin
            rem_d  = rem_q - 1'b1;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      base_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      gerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      gerr_q  <= gerr_d;
    end
  end

  logic [3:0] m_ready_w, m_done_w;
  always_comb begin
    m_ready_w = '0;
    m_done_w  = '0;
    m_ready_w[owner_q] = in_burst & bus.s_ready;
    m_done_w[owner_q]  = in_rel;
  end

  // Beat address wraps naturally at 2^ADDR_W through the truncating add.
  assign bus.s_valid   = s_valid_w;
  assign bus.s_addr    = in_burst ? (base_q + {{(ADDR_W-LEN_W){1'b0}}, beat_q}) : '0;
  assign bus.s_wdata   = in_burst ? own_wdata : '0;
  assign bus.s_last    = in_burst & (rem_q == '0);
  assign bus.m_ready   = m_ready_w;
  assign bus.m_done    = m_done_w;
  assign bus.owner     = owner_q;
  assign bus.bus_busy  = in_burst | in_rel;
  assign bus.grant_err = gerr_q;

endmodule

// File: tb/tb_arb_bus_mux.sv
// Testbench for arb_bus_mux: directed per-cycle vector table, reset corner cases, then random traffic
// checked against a burst-level reference model (queue of expected beat addresses per burst).
module tb_arb_bus_mux;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst_an;
  always #5 clk = ~clk;

  arb_bus_mux_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();
  arb_bus_mux #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (.clk(clk), .rst_an(rst_an), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          sv;
    logic [AW-1:0] sa;
    logic          sl;
    logic [DW-1:0] wd;
    logic [3:0]    mr;
    logic [3:0]    md;
    logic          bb;
    logic          ge;
    logic [1:0]    ow;
  } exp_t;

  typedef struct {
    logic [3:0] g;
    logic [3:0] mv;
    logic       sr;
    logic [2:0] len0;
    exp_t       e;
  } vec_t;

  vec_t vq[$];

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, " s_valid"}, 64'(bus.s_valid), 64'(e.sv));
    if (e.sv) begin
      chk({tag, " s_addr"},  64'(bus.s_addr),  64'(e.sa));
      chk({tag, " s_last"},  64'(bus.s_last),  64'(e.sl));
      chk({tag, " s_wdata"}, 64'(bus.s_wdata), 64'(e.wd));
    end
    chk({tag, " m_ready"},   64'(bus.m_ready),   64'(e.mr));
    chk({tag, " m_done"},    64'(bus.m_done),    64'(e.md));
    chk({tag, " bus_busy"},  64'(bus.bus_busy),  64'(e.bb));
    chk({tag, " grant_err"}, 64'(bus.grant_err), 64'(e.ge));
    chk({tag, " owner"},     64'(bus.owner),     64'(e.ow));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " s_valid"},   64'(bus.s_valid),   64'd0);
    chk({tag, " s_addr"},    64'(bus.s_addr),    64'd0);
    chk({tag, " s_wdata"},   64'(bus.s_wdata),   64'd0);
    chk({tag, " s_last"},    64'(bus.s_last),    64'd0);
    chk({tag, " m_ready"},   64'(bus.m_ready),   64'd0);
    chk({tag, " m_done"},    64'(bus.m_done),    64'd0);
    chk({tag, " bus_busy"},  64'(bus.bus_busy),  64'd0);
    chk({tag, " grant_err"}, 64'(bus.grant_err), 64'd0);
    chk({tag, " owner"},     64'(bus.owner),     64'd0);
  endtask

  function automatic logic [DW-1:0] twd(input logic [1:0] i);
    return 32'hC0DE_0A00 + 32'(i);
  endfunction

  task automatic add(input logic [3:0] g, input logic [3:0] mv, input logic sr, input logic [2:0] len0,
                     input logic sv, input logic [AW-1:0] sa, input logic sl, input logic [3:0] mr,
                     input logic [3:0] md, input logic bb, input logic ge, input logic [1:0] ow);
    vec_t v;
    v.g = g; v.mv = mv; v.sr = sr; v.len0 = len0;
    v.e.sv = sv; v.e.sa = sa; v.e.sl = sl; v.e.wd = twd(ow);
    v.e.mr = mr; v.e.md = md; v.e.bb = bb; v.e.ge = ge; v.e.ow = ow;
    vq.push_back(v);
  endtask

  task automatic set_tab(input logic [3:0] g, input logic [3:0] mv, input logic sr, input logic [2:0] len0);
    bus.grant   = g;
    bus.m_valid = mv;
    bus.s_ready = sr;
    bus.m_addr  = {16'h0300, 16'h00F0, 16'hFFFE, 16'h0100};
    bus.m_len   = {3'd1, 3'd3, 3'd3, len0};
    bus.m_wdata = {twd(2'd3), twd(2'd2), twd(2'd1), twd(2'd0)};
  endtask

  // Reference model: a burst is a queue of the beat addresses still to be sent.
  logic [AW-1:0] mq[$];
  int            m_own;
  bit            m_rel;
  bit            m_gerr;

  task automatic model_reset();
    mq.delete();
    m_own = 0; m_rel = 1'b0; m_gerr = 1'b0;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    bit act;
    act  = (mq.size() > 0);
    e.sv = act && bus.m_valid[m_own];
    e.sa = act ? mq[0] : '0;
    e.sl = (mq.size() == 1);
    e.wd = bus.m_wdata[m_own*DW +: DW];
    e.mr = (act && bus.s_ready) ? 4'(1 << m_own) : 4'd0;
    e.md = m_rel ? 4'(1 << m_own) : 4'd0;
    e.bb = act || m_rel;
    e.ge = m_gerr;
    e.ow = (act || m_rel) ? 2'(m_own) : 2'd0;
    return e;
  endfunction

  task automatic model_step();
    bit ng;
    int k;
    logic [AW-1:0] base;
    int len;
    ng = 1'b0;
    if (mq.size() > 0) begin
      if (bus.m_valid[m_own] && bus.s_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_rel = 1'b1;
      end
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if ($countones(bus.grant) == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (bus.grant[i]) k = i;
      if (bus.m_valid[k]) begin
        base  = bus.m_addr[k*AW +: AW];
        len   = int'(bus.m_len[k*LW +: LW]);
        m_own = k;
        for (int i = 0; i <= len; i++) mq.push_back(AW'(32'(base) + i));
      end
    end else if ($countones(bus.grant) > 1) begin
      ng = 1'b1;
    end
    m_gerr = ng;
  endtask

  initial begin
    exp_t e;
    rst_an = 1'b0;
    set_tab(4'b0, 4'b0, 1'b0, 3'd0);
    #2;
    check_zero("reset");
    @(posedge clk); #1;
    rst_an = 1'b1;

    //   grant    m_valid  srdy len0  sv  s_addr    last m_ready  m_done   busy gerr own
    // single-beat burst from master 0
    add(4'b0001, 4'b0001, 1, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    add(4'b0000, 4'b0001, 1, 3'd0, 1, 16'h0100, 1, 4'b0001, 4'b0000, 1, 0, 2'd0);
    add(4'b0000, 4'b0000, 1, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0001, 1, 0, 2'd0);
    add(4'b0000, 4'b0000, 0, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    // illegal grant, then one-hot grant without m_valid
    add(4'b0011, 4'b0011, 0, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    add(4'b0010, 4'b0000, 0, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 1, 2'd0);
    add(4'b0000, 4'b0000, 0, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    // 4-beat burst master 2 with 2 cycles of backpressure on beat 2
    add(4'b0100, 4'b0100, 1, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    add(4'b0000, 4'b0100, 1, 3'd0, 1, 16'h00F0, 0, 4'b0100, 4'b0000, 1, 0, 2'd2);
    add(4'b0000, 4'b0100, 0, 3'd0, 1, 16'h00F1, 0, 4'b0000, 4'b0000, 1, 0, 2'd2);
    add(4'b0000, 4'b0100, 0, 3'd0, 1, 16'h00F1, 0, 4'b0000, 4'b0000, 1, 0, 2'd2);
    add(4'b0000, 4'b0100, 1, 3'd0, 1, 16'h00F1, 0, 4'b0100, 4'b0000, 1, 0, 2'd2);
    add(4'b0000, 4'b0100, 1, 3'd0, 1, 16'h00F2, 0, 4'b0100, 4'b0000, 1, 0, 2'd2);
    add(4'b0000, 4'b0100, 1, 3'd0, 1, 16'h00F3, 1, 4'b0100, 4'b0000, 1, 0, 2'd2);
    add(4'b0000, 4'b0000, 1, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0100, 1, 0, 2'd2);
    add(4'b0000, 4'b0000, 1, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    // address wrap on master 1
    add(4'b0010, 4'b0010, 1, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    add(4'b0000, 4'b0010, 1, 3'd0, 1, 16'hFFFE, 0, 4'b0010, 4'b0000, 1, 0, 2'd1);
    add(4'b0000, 4'b0010, 1, 3'd0, 1, 16'hFFFF, 0, 4'b0010, 4'b0000, 1, 0, 2'd1);
    add(4'b0000, 4'b0010, 1, 3'd0, 1, 16'h0000, 0, 4'b0010, 4'b0000, 1, 0, 2'd1);
    add(4'b0000, 4'b0010, 1, 3'd0, 1, 16'h0001, 1, 4'b0010, 4'b0000, 1, 0, 2'd1);
    add(4'b0000, 4'b0000, 1, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0010, 1, 0, 2'd1);
    add(4'b0000, 4'b0000, 1, 3'd0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    // grant moves to master 3 mid-burst; master 0 keeps the bus
    add(4'b0001, 4'b1001, 1, 3'd3, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    add(4'b0001, 4'b1001, 1, 3'd3, 1, 16'h0100, 0, 4'b0001, 4'b0000, 1, 0, 2'd0);
    add(4'b1000, 4'b1001, 1, 3'd3, 1, 16'h0101, 0, 4'b0001, 4'b0000, 1, 0, 2'd0);
    add(4'b1000, 4'b1001, 1, 3'd3, 1, 16'h0102, 0, 4'b0001, 4'b0000, 1, 0, 2'd0);
    add(4'b1000, 4'b1001, 1, 3'd3, 1, 16'h0103, 1, 4'b0001, 4'b0000, 1, 0, 2'd0);
    add(4'b1000, 4'b1000, 1, 3'd3, 0, 16'h0000, 0, 4'b0000, 4'b0001, 1, 0, 2'd0);
    add(4'b1000, 4'b1000, 1, 3'd3, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    add(4'b1000, 4'b1000, 1, 3'd3, 1, 16'h0300, 0, 4'b1000, 4'b0000, 1, 0, 2'd3);
    add(4'b0000, 4'b1000, 1, 3'd3, 1, 16'h0301, 1, 4'b1000, 4'b0000, 1, 0, 2'd3);
    add(4'b0000, 4'b0000, 1, 3'd3, 0, 16'h0000, 0, 4'b0000, 4'b1000, 1, 0, 2'd3);
    add(4'b0000, 4'b0000, 1, 3'd3, 0, 16'h0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);

    for (int r = 0; r < vq.size(); r++) begin
      set_tab(vq[r].g, vq[r].mv, vq[r].sr, vq[r].len0);
      #1;
      check_out($sformatf("row%0d", r), vq[r].e);
      @(posedge clk); #1;
    end

    // Reset during beat 3 of a 4-beat burst, then a fresh burst from master 0.
    set_tab(4'b0001, 4'b0001, 1'b1, 3'd3);
    @(posedge clk); #1;
    bus.grant = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst s_addr", 64'(bus.s_addr), 64'h0102);
    rst_an = 1'b0;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_zero($sformatf("rst_hold%0d", i));
    end
    rst_an = 1'b1;
    bus.grant = 4'b0001;
    @(posedge clk); #1;
    bus.grant = 4'b0000;
    chk("post_rst s_valid", 64'(bus.s_valid), 64'd1);
    chk("post_rst s_addr",  64'(bus.s_addr),  64'h0100);
    chk("post_rst owner",   64'(bus.owner),   64'd0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst beat%0d s_addr", i), 64'(bus.s_addr), 64'(16'h0100 + i));
    end
    @(posedge clk); #1;
    chk("post_rst m_done", 64'(bus.m_done), 64'b0001);

    // Randomized traffic against the burst-level model.
    set_tab(4'b0, 4'b0, 1'b0, 3'd0);
    rst_an = 1'b0;
    #2;
    rst_an = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int c = 0; c < 2500; c++) begin
      case ($urandom_range(0, 9))
        6:       bus.grant = 4'b0000;
        7, 8, 9: bus.grant = 4'($urandom_range(0, 15));
        default: bus.grant = 4'(1 << $urandom_range(0, 3));
      endcase
      for (int i = 0; i < 4; i++) bus.m_valid[i] = ($urandom_range(0, 3) != 0);
      bus.s_ready = ($urandom_range(0, 9) < 7);
      bus.m_addr  = {$urandom, $urandom};
      bus.m_wdata = {$urandom, $urandom, $urandom, $urandom};
      bus.m_len   = 12'($urandom_range(0, 4095));
      #1;
      e = model_exp();
      check_out($sformatf("rnd%0d", c), e);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
